// File: rtl/safety_boot_ctrl.sv
// -----------------------------------------------------------------------------
// safety_boot_ctrl
//
// Boot-control register responder for the safety island. A memory-mapped
// subordinate on the island peripheral bus that samples the boot strap after a
// short hold period, sequences the CV32RT core start-up (boot address and
// fetch enable) and collects the end-of-computation status written back by
// the core.
//
// Register map (word offsets on addr_i[7:0], bits [1:0] ignored):
//   0x00 BOOTADDR    RW  boot address driven to the core
//   0x04 FETCHEN     RW  bit0 only, upper bits read 0
//   0x08 CORESTATUS  RW  bit31 = EOC, bits [30:0] = exit code
//   0x0C BOOTMODE    RO  strap value latched when HOLD exits
//   0x10 STATE       RO  boot FSM encoding
//   anything else    error response, read data 0, no state change
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   bootmode_i[1:0]      boot strap (01 = Preloaded, all others = Jtag)
//   req_i / gnt_o        bus request / grant (grant is combinational)
//   addr_i, we_i, be_i,
//   wdata_i              request address, write enable, byte enables, data
//   rvalid_o, rdata_o,
//   err_o                response, one cycle after the request
//   boot_addr_o          BOOTADDR to the core
//   fetch_en_o           fetch enable to the core (registered)
//   eoc_o, exit_code_o   CORESTATUS fields
// -----------------------------------------------------------------------------
module safety_boot_ctrl #(
    parameter logic [31:0] BootAddrDefault = 32'h0000_0080,
    // Number of cycles spent in HOLD before the strap is evaluated (1..255).
    parameter int unsigned ResetHoldCycles = 8
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [1:0]  bootmode_i,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic [31:0] boot_addr_o,
    output logic        fetch_en_o,
    output logic        eoc_o,
    output logic [30:0] exit_code_o
);

    // -------------------------------------------------------------------------
    // Constants
    // -------------------------------------------------------------------------
    localparam logic [1:0] ST_HOLD       = 2'd0;
    localparam logic [1:0] ST_WAIT_FETCH = 2'd1;
    localparam logic [1:0] ST_RUN        = 2'd2;
    localparam logic [1:0] ST_DONE       = 2'd3;

    localparam logic [5:0] OFF_BOOTADDR   = 6'd0;
    localparam logic [5:0] OFF_FETCHEN    = 6'd1;
    localparam logic [5:0] OFF_CORESTATUS = 6'd2;
    localparam logic [5:0] OFF_BOOTMODE   = 6'd3;
    localparam logic [5:0] OFF_STATE      = 6'd4;

    localparam logic [1:0] MODE_PRELOADED = 2'b01;

    localparam logic [7:0] HOLD_LAST = 8'(ResetHoldCycles - 1);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [1:0]  state_q, state_next;
    logic [7:0]  hold_cnt_q, hold_cnt_next;
    logic [31:0] bootaddr_q, bootaddr_next;
    logic        fetchen_q, fetchen_next;
    logic [31:0] status_q, status_next;
    logic [1:0]  bootmode_q, bootmode_next;
    logic        fetch_en_q;

    logic        rvalid_q;
    logic        err_q;
    logic [31:0] rdata_q;

    // -------------------------------------------------------------------------
    // Address decode
    // -------------------------------------------------------------------------
    logic [5:0]  word_off;
    logic        addr_valid;
    logic        wr_en;
    logic        rd_en;
    logic        wr_bootaddr;
    logic        wr_fetchen;
    logic        wr_status;
    logic        unused_addr;

    assign word_off    = addr_i[7:2];
    assign addr_valid  = (word_off <= OFF_STATE);
    assign wr_en       = req_i & we_i & addr_valid;
    assign rd_en       = req_i & ~we_i & addr_valid;
    assign wr_bootaddr = wr_en & (word_off == OFF_BOOTADDR);
    assign wr_fetchen  = wr_en & (word_off == OFF_FETCHEN);
    assign wr_status   = wr_en & (word_off == OFF_CORESTATUS);

    // Only the low byte of the address is decoded, and byte lanes come from be_i.
    assign unused_addr = ^{addr_i[31:8], addr_i[1:0]};

    // Every request is accepted in the cycle it is presented.
    assign gnt_o = req_i;

    // Events that drive the boot FSM out of RUN/DONE. They look at the write
    // itself rather than the stored value so that the transition happens on
    // the same edge the write lands.
    logic eoc_write;
    logic fetch_clear;
    logic hold_done;

    assign eoc_write   = wr_status & be_i[3] & wdata_i[31];
    assign fetch_clear = wr_fetchen & be_i[0] & ~wdata_i[0];
    assign hold_done   = (state_q == ST_HOLD) && (hold_cnt_q == HOLD_LAST);

    // Byte-lane merge of a write into a 32-bit register.
    function automatic logic [31:0] merge_bytes(input logic [31:0] cur,
                                                input logic [31:0] data,
                                                input logic [3:0]  lanes);
        logic [31:0] res;
        res = cur;
        for (int i = 0; i < 4; i++) begin
            if (lanes[i]) begin
                res[8*i +: 8] = data[8*i +: 8];
            end
        end
        return res;
    endfunction

    // -------------------------------------------------------------------------
    // Register write path and boot FSM
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal assigned here gets a default first so that no
        // path through the block leaves it unassigned and infers a latch.
        bootaddr_next = bootaddr_q;
        fetchen_next  = fetchen_q;
        status_next   = status_q;
        bootmode_next = bootmode_q;
        hold_cnt_next = hold_cnt_q;
        state_next    = state_q;

        if (wr_bootaddr) begin
            bootaddr_next = merge_bytes(bootaddr_q, wdata_i, be_i);
        end
        if (wr_fetchen && be_i[0]) begin
            fetchen_next = wdata_i[0];
        end
        if (wr_status) begin
            status_next = merge_bytes(status_q, wdata_i, be_i);
        end

        unique case (state_q)
            ST_HOLD: begin
                if (hold_done) begin
                    bootmode_next = bootmode_i;
                    if (bootmode_i == MODE_PRELOADED) begin
                        // Preloaded image: start the core straight away and
                        // reflect that in FETCHEN, overriding any bus write
                        // that landed on the exit edge.
                        fetchen_next = 1'b1;
                        state_next   = ST_RUN;
                    end else begin
                        // Jtag and both reserved strap values wait for the host.
                        state_next = ST_WAIT_FETCH;
                    end
                end else begin
                    hold_cnt_next = hold_cnt_q + 8'd1;
                end
            end
            ST_WAIT_FETCH: begin
                if (fetchen_next) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (eoc_write) begin
                    state_next = ST_DONE;
                end else if (fetch_clear) begin
                    state_next = ST_WAIT_FETCH;
                end
            end
            ST_DONE: begin
                if (fetch_clear) begin
                    state_next = ST_WAIT_FETCH;
                end
            end
            default: state_next = ST_HOLD;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_HOLD;
            hold_cnt_q <= 8'd0;
            bootaddr_q <= BootAddrDefault;
            fetchen_q  <= 1'b0;
            status_q   <= 32'd0;
            bootmode_q <= 2'd0;
            fetch_en_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples the pre-edge values regardless of statement order.
            state_q    <= state_next;
            hold_cnt_q <= hold_cnt_next;
            bootaddr_q <= bootaddr_next;
            fetchen_q  <= fetchen_next;
            status_q   <= status_next;
            bootmode_q <= bootmode_next;
            fetch_en_q <= (state_next == ST_RUN) || (state_next == ST_DONE);
        end
    end

    // -------------------------------------------------------------------------
    // Read path and response
    // -------------------------------------------------------------------------
    logic [31:0] rd_mux;

    always_comb begin
        rd_mux = 32'd0;
        unique case (word_off)
            OFF_BOOTADDR:   rd_mux = bootaddr_q;
            OFF_FETCHEN:    rd_mux = {31'd0, fetchen_q};
            OFF_CORESTATUS: rd_mux = status_q;
            OFF_BOOTMODE:   rd_mux = {30'd0, bootmode_q};
            OFF_STATE:      rd_mux = {30'd0, state_q};
            default:        rd_mux = 32'd0;
        endcase
    end

    // Reads return the register contents from before any write on the same
    // edge; writes and errors always answer with zero data.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= 32'd0;
        end else begin
            rvalid_q <= req_i;
            err_q    <= req_i & ~addr_valid;
            rdata_q  <= rd_en ? rd_mux : 32'd0;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign rvalid_o    = rvalid_q;
    assign err_o       = err_q;
    assign rdata_o     = rdata_q;
    assign boot_addr_o = bootaddr_q;
    assign fetch_en_o  = fetch_en_q;
    assign eoc_o       = status_q[31];
    assign exit_code_o = status_q[30:0];

endmodule

// File: tb/tb_safety_boot_ctrl.sv
// -----------------------------------------------------------------------------
// tb_safety_boot_ctrl
//
// Self-checking bench for safety_boot_ctrl. Directed scenarios cover the boot
// flows and bus rules; a randomized phase compares every cycle against a
// behavioural model of the register file and boot sequence.
// -----------------------------------------------------------------------------
module tb_safety_boot_ctrl;

    localparam logic [31:0] BOOT_DEFAULT = 32'h0000_0080;
    localparam int          HOLD_CYCLES  = 8;

    logic        clk_i;
    logic        rst_ni;
    logic [1:0]  bootmode_i;
    logic        req_i;
    logic        gnt_o;
    logic [31:0] addr_i;
    logic        we_i;
    logic [3:0]  be_i;
    logic [31:0] wdata_i;
    logic        rvalid_o;
    logic [31:0] rdata_o;
    logic        err_o;
    logic [31:0] boot_addr_o;
    logic        fetch_en_o;
    logic        eoc_o;
    logic [30:0] exit_code_o;

    int checks;
    int errors;
    logic gnt_seen;

    safety_boot_ctrl #(
        .BootAddrDefault(BOOT_DEFAULT),
        .ResetHoldCycles(HOLD_CYCLES)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .bootmode_i (bootmode_i),
        .req_i      (req_i),
        .gnt_o      (gnt_o),
        .addr_i     (addr_i),
        .we_i       (we_i),
        .be_i       (be_i),
        .wdata_i    (wdata_i),
        .rvalid_o   (rvalid_o),
        .rdata_o    (rdata_o),
        .err_o      (err_o),
        .boot_addr_o(boot_addr_o),
        .fetch_en_o (fetch_en_o),
        .eoc_o      (eoc_o),
        .exit_code_o(exit_code_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // -------------------------------------------------------------------------
    // Behavioural model: registers by name, boot phase as a number 0..3,
    // and a count of cycles elapsed in the hold phase.
    // -------------------------------------------------------------------------
    logic [31:0] m_bootaddr;
    logic        m_fetchen;
    logic [31:0] m_status;
    logic [1:0]  m_bootmode;
    int          m_state;
    int          m_hold;
    logic        m_rvalid;
    logic        m_err;
    logic [31:0] m_rdata;

    task automatic model_reset();
        m_bootaddr = BOOT_DEFAULT;
        m_fetchen  = 1'b0;
        m_status   = 32'd0;
        m_bootmode = 2'd0;
        m_state    = 0;
        m_hold     = 0;
        m_rvalid   = 1'b0;
        m_err      = 1'b0;
        m_rdata    = 32'd0;
    endtask

    function automatic logic [31:0] model_read(input int off);
        case (off)
            0:       return m_bootaddr;
            1:       return {31'd0, m_fetchen};
            2:       return m_status;
            3:       return {30'd0, m_bootmode};
            4:       return 32'(m_state);
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] model_merge(input logic [31:0] cur,
                                                input logic [31:0] d,
                                                input logic [3:0]  b);
        logic [31:0] res;
        res = cur;
        for (int i = 0; i < 4; i++) if (b[i]) res[8*i +: 8] = d[8*i +: 8];
        return res;
    endfunction

    task automatic model_edge(input logic r, input logic w, input logic [31:0] a,
                              input logic [3:0] b, input logic [31:0] d,
                              input logic [1:0] strap);
        int off;
        bit valid;
        bit do_wr;
        off   = int'(a[7:2]);
        valid = (off <= 4);
        do_wr = r && w && valid;
        m_rvalid = r;
        m_err    = r && !valid;
        m_rdata  = (r && !w && valid) ? model_read(off) : 32'd0;
        if (do_wr && off == 0) m_bootaddr = model_merge(m_bootaddr, d, b);
        if (do_wr && off == 1 && b[0]) m_fetchen = d[0];
        if (do_wr && off == 2) m_status = model_merge(m_status, d, b);
        case (m_state)
            0: begin
                if (m_hold == HOLD_CYCLES - 1) begin
                    m_bootmode = strap;
                    if (strap == 2'b01) begin
                        m_state   = 2;
                        m_fetchen = 1'b1;
                    end else begin
                        m_state = 1;
                    end
                end else begin
                    m_hold++;
                end
            end
            1: if (m_fetchen) m_state = 2;
            2: begin
                if (do_wr && off == 2 && b[3] && d[31]) m_state = 3;
                else if (do_wr && off == 1 && b[0] && !d[0]) m_state = 1;
            end
            default: if (do_wr && off == 1 && b[0] && !d[0]) m_state = 1;
        endcase
    endtask

    // -------------------------------------------------------------------------
    // Stimulus primitives (called at a falling edge, return at the next one)
    // -------------------------------------------------------------------------
    task automatic step(input logic r, input logic w, input logic [31:0] a,
                        input logic [3:0] b, input logic [31:0] d);
        req_i   = r;
        we_i    = w;
        addr_i  = a;
        be_i    = b;
        wdata_i = d;
        #1 gnt_seen = gnt_o;
        @(posedge clk_i);
        model_edge(r, w, a, b, d, bootmode_i);
        @(negedge clk_i);
    endtask

    task automatic rd(input logic [31:0] a);
        step(1'b1, 1'b0, a, 4'hF, 32'd0);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        step(1'b1, 1'b1, a, 4'hF, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'd0, 4'h0, 32'd0);
    endtask

    task automatic apply_reset(input logic [1:0] mode);
        @(negedge clk_i);
        rst_ni     = 1'b0;
        req_i      = 1'b0;
        we_i       = 1'b0;
        bootmode_i = mode;
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        model_reset();
    endtask

    // -------------------------------------------------------------------------
    // Scenarios
    // -------------------------------------------------------------------------
    task automatic test_reset();
        @(negedge clk_i);
        rst_ni     = 1'b0;
        bootmode_i = 2'b01;
        req_i      = 1'b1;
        we_i       = 1'b0;
        addr_i     = 32'h0;
        be_i       = 4'hF;
        wdata_i    = 32'h0;
        #1;
        checks++;
        if (gnt_o !== 1'b1) begin
            errors++; $display("FAIL reset_gnt: got %b want 1", gnt_o);
        end
        @(posedge clk_i); @(negedge clk_i);
        checks++;
        if ({rvalid_o, err_o, rdata_o} !== 34'd0) begin
            errors++; $display("FAIL reset_resp: rvalid %b err %b rdata %h want 0", rvalid_o, err_o, rdata_o);
        end
        checks++;
        if (boot_addr_o !== BOOT_DEFAULT || fetch_en_o !== 1'b0) begin
            errors++; $display("FAIL reset_core: boot_addr %h fetch_en %b want %h 0", boot_addr_o, fetch_en_o, BOOT_DEFAULT);
        end
        checks++;
        if (eoc_o !== 1'b0 || exit_code_o !== 31'd0) begin
            errors++; $display("FAIL reset_status: eoc %b exit %h want 0 0", eoc_o, exit_code_o);
        end
        req_i = 1'b0;
    endtask

    task automatic test_preloaded_boot();
        apply_reset(2'b01);
        for (int k = 1; k <= HOLD_CYCLES + 2; k++) begin
            idle(1);
            checks++;
            if (fetch_en_o !== (k >= HOLD_CYCLES)) begin
                errors++; $display("FAIL preload_fetch_en_cycle%0d: got %b want %b", k, fetch_en_o, (k >= HOLD_CYCLES));
            end
        end
        rd(32'h04);
        checks++;
        if (rdata_o !== 32'd1 || rvalid_o !== 1'b1) begin
            errors++; $display("FAIL preload_read_fetchen: rdata %h rvalid %b want 1 1", rdata_o, rvalid_o);
        end
        rd(32'h10);
        checks++;
        if (rdata_o !== 32'd2) begin
            errors++; $display("FAIL preload_read_state: got %h want 2", rdata_o);
        end
        rd(32'h0C);
        checks++;
        if (rdata_o !== 32'd1) begin
            errors++; $display("FAIL preload_read_bootmode: got %h want 1", rdata_o);
        end
    endtask

    task automatic test_jtag_boot();
        apply_reset(2'b00);
        idle(HOLD_CYCLES + 4);
        rd(32'h10);
        checks++;
        if (rdata_o !== 32'd1 || fetch_en_o !== 1'b0) begin
            errors++; $display("FAIL jtag_wait_state: state %h fetch_en %b want 1 0", rdata_o, fetch_en_o);
        end
        wr(32'h00, 32'h0000_1000);
        checks++;
        if (boot_addr_o !== 32'h0000_1000 || rdata_o !== 32'd0 || err_o !== 1'b0) begin
            errors++; $display("FAIL jtag_bootaddr: boot_addr %h rdata %h err %b want 1000 0 0", boot_addr_o, rdata_o, err_o);
        end
        checks++;
        if (fetch_en_o !== 1'b0) begin
            errors++; $display("FAIL jtag_fetch_early: got %b want 0", fetch_en_o);
        end
        wr(32'h04, 32'd1);
        checks++;
        if (fetch_en_o !== 1'b1) begin
            errors++; $display("FAIL jtag_fetch_rise: got %b want 1", fetch_en_o);
        end
        rd(32'h10);
        checks++;
        if (rdata_o !== 32'd2) begin
            errors++; $display("FAIL jtag_run_state: got %h want 2", rdata_o);
        end
    endtask

    // Continues from the RUN state left by test_jtag_boot.
    task automatic test_eoc();
        wr(32'h08, 32'h8000_0005);
        checks++;
        if (eoc_o !== 1'b1 || exit_code_o !== 31'd5) begin
            errors++; $display("FAIL eoc_status: eoc %b exit %h want 1 5", eoc_o, exit_code_o);
        end
        rd(32'h10);
        checks++;
        if (rdata_o !== 32'd3 || fetch_en_o !== 1'b1) begin
            errors++; $display("FAIL eoc_done_state: state %h fetch_en %b want 3 1", rdata_o, fetch_en_o);
        end
        wr(32'h04, 32'd0);
        checks++;
        if (fetch_en_o !== 1'b0 || eoc_o !== 1'b1) begin
            errors++; $display("FAIL eoc_fetch_clear: fetch_en %b eoc %b want 0 1", fetch_en_o, eoc_o);
        end
        rd(32'h10);
        checks++;
        if (rdata_o !== 32'd1) begin
            errors++; $display("FAIL eoc_wait_state: got %h want 1", rdata_o);
        end
    endtask

    task automatic test_bus_rules();
        apply_reset(2'b00);
        step(1'b1, 1'b1, 32'h00, 4'b0100, 32'hAABB_CCDD);
        checks++;
        if (boot_addr_o !== 32'h00BB_0080) begin
            errors++; $display("FAIL bus_byte_enable: got %h want 00bb0080", boot_addr_o);
        end
        // Back-to-back: the read issued right after the write sees it.
        rd(32'h00);
        checks++;
        if (rdata_o !== 32'h00BB_0080) begin
            errors++; $display("FAIL bus_read_after_write: got %h want 00bb0080", rdata_o);
        end
        step(1'b1, 1'b1, 32'h00, 4'b0000, 32'h1234_5678);
        checks++;
        if (boot_addr_o !== 32'h00BB_0080 || err_o !== 1'b0 || rvalid_o !== 1'b1) begin
            errors++; $display("FAIL bus_be_zero: boot_addr %h err %b rvalid %b want 00bb0080 0 1", boot_addr_o, err_o, rvalid_o);
        end
        rd(32'h14);
        checks++;
        if (err_o !== 1'b1 || rdata_o !== 32'd0 || rvalid_o !== 1'b1) begin
            errors++; $display("FAIL bus_bad_addr: err %b rdata %h rvalid %b want 1 0 1", err_o, rdata_o, rvalid_o);
        end
        idle(1);
        checks++;
        if (rvalid_o !== 1'b0 || err_o !== 1'b0) begin
            errors++; $display("FAIL bus_idle_resp: rvalid %b err %b want 0 0", rvalid_o, err_o);
        end
        idle(HOLD_CYCLES);
        wr(32'h0C, 32'h3);
        checks++;
        if (err_o !== 1'b0) begin
            errors++; $display("FAIL bus_ro_write_err: got %b want 0", err_o);
        end
        rd(32'h0C);
        checks++;
        if (rdata_o !== 32'd0) begin
            errors++; $display("FAIL bus_ro_unchanged: got %h want 0", rdata_o);
        end
    endtask

    task automatic test_hold_write();
        apply_reset(2'b00);
        wr(32'h04, 32'd1);
        for (int k = 2; k <= HOLD_CYCLES + 2; k++) begin
            idle(1);
            checks++;
            if (fetch_en_o !== (k >= HOLD_CYCLES + 1)) begin
                errors++; $display("FAIL hold_fetchen_cycle%0d: got %b want %b", k, fetch_en_o, (k >= HOLD_CYCLES + 1));
            end
        end
    endtask

    task automatic test_reserved_mode();
        apply_reset(2'b11);
        idle(HOLD_CYCLES + 1);
        rd(32'h0C);
        checks++;
        if (rdata_o !== 32'd3) begin
            errors++; $display("FAIL reserved_bootmode: got %h want 3", rdata_o);
        end
        rd(32'h10);
        checks++;
        if (rdata_o !== 32'd1 || fetch_en_o !== 1'b0) begin
            errors++; $display("FAIL reserved_jtag_like: state %h fetch_en %b want 1 0", rdata_o, fetch_en_o);
        end
        bootmode_i = 2'b01;
        idle(3);
        rd(32'h0C);
        checks++;
        if (rdata_o !== 32'd3 || fetch_en_o !== 1'b0) begin
            errors++; $display("FAIL strap_change_ignored: bootmode %h fetch_en %b want 3 0", rdata_o, fetch_en_o);
        end
    endtask

    // Continues from WAIT_FETCH left by test_reserved_mode.
    task automatic test_midrun_reset();
        wr(32'h04, 32'd1);
        wr(32'h08, 32'h8000_0007);
        rd(32'h10);
        checks++;
        if (rdata_o !== 32'd3 || eoc_o !== 1'b1) begin
            errors++; $display("FAIL midrun_done: state %h eoc %b want 3 1", rdata_o, eoc_o);
        end
        req_i  = 1'b1;
        we_i   = 1'b0;
        addr_i = 32'h08;
        #2 rst_ni = 1'b0;
        #1;
        checks++;
        if (fetch_en_o !== 1'b0 || eoc_o !== 1'b0 || exit_code_o !== 31'd0 ||
            boot_addr_o !== BOOT_DEFAULT || rvalid_o !== 1'b0 || rdata_o !== 32'd0 || err_o !== 1'b0) begin
            errors++; $display("FAIL midrun_async_reset: fetch_en %b eoc %b exit %h boot %h rvalid %b rdata %h err %b",
                               fetch_en_o, eoc_o, exit_code_o, boot_addr_o, rvalid_o, rdata_o, err_o);
        end
        @(posedge clk_i); @(negedge clk_i);
        checks++;
        if (rvalid_o !== 1'b0) begin
            errors++; $display("FAIL midrun_resp_dropped: got %b want 0", rvalid_o);
        end
        rst_ni = 1'b1;
        model_reset();
        rd(32'h10);
        checks++;
        if (rdata_o !== 32'd0 || fetch_en_o !== 1'b0) begin
            errors++; $display("FAIL midrun_rehold: state %h fetch_en %b want 0 0", rdata_o, fetch_en_o);
        end
    endtask

    task automatic test_random(input int cycles);
        logic        r;
        logic        w;
        logic [31:0] tmp;
        logic [31:0] a;
        logic [5:0]  off;
        apply_reset(2'($urandom_range(0, 3)));
        for (int i = 0; i < cycles; i++) begin
            if ($urandom_range(0, 49) == 0) bootmode_i = 2'($urandom_range(0, 3));
            r   = ($urandom_range(0, 3) != 0);
            w   = 1'($urandom_range(0, 1));
            off = 6'($urandom_range(0, 9));
            tmp = $urandom;
            a   = {tmp[31:8], off, tmp[1:0]};
            step(r, w, a, 4'($urandom_range(0, 15)), $urandom);
            checks++;
            if (gnt_seen !== r) begin
                errors++; $display("FAIL rand_gnt[%0d]: got %b want %b", i, gnt_seen, r);
            end
            checks++;
            if (rvalid_o !== m_rvalid || err_o !== m_err || rdata_o !== m_rdata) begin
                errors++; $display("FAIL rand_resp[%0d]: rvalid %b err %b rdata %h want %b %b %h",
                                   i, rvalid_o, err_o, rdata_o, m_rvalid, m_err, m_rdata);
            end
            checks++;
            if (boot_addr_o !== m_bootaddr || fetch_en_o !== (m_state >= 2)) begin
                errors++; $display("FAIL rand_core[%0d]: boot %h fetch_en %b want %h %b",
                                   i, boot_addr_o, fetch_en_o, m_bootaddr, (m_state >= 2));
            end
            checks++;
            if (eoc_o !== m_status[31] || exit_code_o !== m_status[30:0]) begin
                errors++; $display("FAIL rand_status[%0d]: eoc %b exit %h want %b %h",
                                   i, eoc_o, exit_code_o, m_status[31], m_status[30:0]);
            end
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst_ni     = 1'b0;
        bootmode_i = 2'b00;
        req_i      = 1'b0;
        we_i       = 1'b0;
        addr_i     = 32'd0;
        be_i       = 4'd0;
        wdata_i    = 32'd0;
        gnt_seen   = 1'b0;
        model_reset();

        test_reset();
        test_preloaded_boot();
        test_jtag_boot();
        test_eoc();
        test_bus_rules();
        test_hold_write();
        test_reserved_mode();
        test_midrun_reset();
        test_random(300);
        test_random(300);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/safety_boot_ctrl.md
# safety_boot_ctrl

Boot-control register responder for the safety island. It sits on the island's peripheral bus as a memory-mapped subordinate. It consumes the `bootmode_e` strap and sequences core start-up: it drives the boot address and fetch-enable to the CV32RT core, and it collects the end-of-computation status the core writes back. It is the receiving end of the boot flow that the host (JTAG debugger or preloader) initiates.

## Interface
Parameters:
- `BootAddrDefault`, `32'h0000_0080`: reset value of BOOTADDR.
- `ResetHoldCycles`, `8`: cycles held in HOLD after reset before the boot mode is evaluated. Legal range is 1..255.

Ports:
- `clk_i` in 1: single clock.
- `rst_ni` in 1: reset, asynchronous and active-low.
- `bootmode_i` in 2: boot strap. `2'b00` = Jtag, `2'b01` = Preloaded; `2'b10` and `2'b11` are treated as Jtag.
- `req_i` in 1: bus request.
- `gnt_o` out 1: grant.
- `addr_i` in 32: byte address. Only bits [7:0] are decoded.
- `we_i` in 1: write enable.
- `be_i` in 4: byte enables.
- `wdata_i` in 32: write data.
- `rvalid_o` out 1: response valid.
- `rdata_o` out 32: read data.
- `err_o` out 1: error response.
- `boot_addr_o` out 32: boot address to the core.
- `fetch_en_o` out 1: fetch enable to the core.
- `eoc_o` out 1: end of computation.
- `exit_code_o` out 31: exit code from CORESTATUS.

## Operation
Register map (word offsets on `addr_i[7:0]`; bits [1:0] ignored):
- 0x00 BOOTADDR, RW, resets to `BootAddrDefault`.
- 0x04 FETCHEN, RW bit0. Bits [31:1] read 0.
- 0x08 CORESTATUS, RW, resets to 0. Bit31 = EOC, bits [30:0] = exit code.
- 0x0C BOOTMODE, RO. Latched `bootmode_i` in bits [1:0].
- 0x10 STATE, RO. FSM encoding in bits [1:0].
- Any other offset returns an error: `err_o`=1, `rdata_o`=0, no state change.
- Writes to RO registers are ignored and do not return an error.
- Writes honour `be_i` per byte. `be_i`=0 is a legal no-op write.

Boot FSM:
- States: HOLD=0, WAIT_FETCH=1, RUN=2, DONE=3.
- HOLD:
  - An 8-bit counter counts up from 0.
  - When the count reaches `ResetHoldCycles-1`, the FSM latches `bootmode_i` into BOOTMODE.
  - Preloaded: go to RUN and set FETCHEN=1 in the same cycle.
  - Jtag or reserved value: go to WAIT_FETCH.
  - Bus writes to FETCHEN during HOLD are stored but have no effect until HOLD exits.
- WAIT_FETCH: go to RUN when FETCHEN=1.
- RUN:
  - A write that sets CORESTATUS bit31=1 moves the FSM to DONE.
  - A write that clears FETCHEN moves the FSM to WAIT_FETCH.
- DONE: a write that clears FETCHEN moves the FSM to WAIT_FETCH. CORESTATUS is retained.
- `bootmode_i` changes after HOLD exits are ignored until the next reset.

Outputs:
- `fetch_en_o` = (state==RUN or state==DONE), registered.
- `boot_addr_o` = BOOTADDR.
- `eoc_o` = CORESTATUS[31].
- `exit_code_o` = CORESTATUS[30:0].
- BOOTADDR may be rewritten at any time. Its effect on the core is the integrator's concern.

## Timing
- `gnt_o` = `req_i` (combinational). Every request is accepted in the cycle it is presented.
- Response: `rvalid_o` and `err_o`/`rdata_o` appear exactly 1 cycle after the accepted request, for reads and writes alike. On writes, `rdata_o`=0.
- Back-to-back requests are supported at 1 per cycle.
- A register write is visible to a read issued in the following cycle. FSM transitions caused by a write occur on that same write edge, so STATE and outputs change 1 cycle after the request.
- Reset values: `gnt_o`=`req_i`, `rvalid_o`=0, `err_o`=0, `rdata_o`=0, `boot_addr_o`=`BootAddrDefault`, `fetch_en_o`=0, `eoc_o`=0, `exit_code_o`=0. FSM=HOLD, counter=0, BOOTMODE=0.
- Preloaded boot: `fetch_en_o` rises `ResetHoldCycles` cycles after the first clock edge with `rst_ni` high.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous). Any in-flight response is dropped.

## Test plan
- Preloaded boot: hold `bootmode_i`=01 through reset release -> `fetch_en_o` rises at cycle 8. Reading 0x04 then returns 1 and reading 0x10 returns 2.
- Jtag boot: `bootmode_i`=00; write 0x0000_1000 to 0x00, then write 1 to 0x04 -> `boot_addr_o`=0x1000 and `fetch_en_o` rises the cycle after the FETCHEN write, not before.
- EOC: in RUN, write 0x8000_0005 to 0x08 -> `eoc_o`=1, `exit_code_o`=5, STATE=3. Then write 0 to 0x04 -> `fetch_en_o`=0, STATE=1, and `eoc_o` stays 1.
- Bus rules: write 0xAABBCCDD to 0x00 with `be_i`=0100 -> BOOTADDR = 0x00BB_0080. Read 0x14 -> `err_o`=1, `rdata_o`=0. Write to 0x0C -> `err_o`=0 and BOOTMODE is unchanged.
- Reserved mode and strap change: `bootmode_i`=11 -> Jtag behaviour and BOOTMODE reads 3. Change `bootmode_i` after HOLD -> BOOTMODE is unchanged.
- Mid-run reset: assert `rst_ni` low while in DONE -> all outputs return to reset values asynchronously. After release the FSM re-enters HOLD.
